// File: rtl/pes_alu_pkg.sv
// Shared defaults and FSM state encoding for the ALU request scheduler.
package pes_alu_pkg;

   localparam int N_REQ_D   = 4;
   localparam int DATA_W_D  = 8;
   localparam int OP_W_D    = 3;
   localparam int ALU_LAT_D = 1;
   localparam int CNT_W     = 3;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_t;

endpackage

// File: rtl/pes_rr_arb.sv
// Round-robin picker: first requester at or above ptr, wrapping.
module pes_rr_arb #(
   parameter int N_REQ = 4,
   localparam int IW   = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [IW-1:0]    ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IW-1:0]    idx
);

   int   j;
   logic found;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < N_REQ; k++) begin
         j = (int'(ptr) + k) % N_REQ;
         if (!found && req[j]) begin
            found    = 1'b1;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/pes_alu_sched.sv
// Time-shares one external ALU among N_REQ requesters, one op in flight.
module pes_alu_sched
   import pes_alu_pkg::*;
#(
   parameter int N_REQ   = N_REQ_D,
   parameter int DATA_W  = DATA_W_D,
   parameter int OP_W    = OP_W_D,
   parameter int ALU_LAT = ALU_LAT_D
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_a,
   input  logic [N_REQ*DATA_W-1:0] req_b,
   input  logic [N_REQ*OP_W-1:0]   req_op,
   output logic [N_REQ-1:0]        gnt,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]       rsp_data,
   output logic                    busy,
   output logic [DATA_W-1:0]       alu_a,
   output logic [DATA_W-1:0]       alu_b,
   output logic [OP_W-1:0]         alu_op,
   input  logic [DATA_W-1:0]       alu_r
);

   localparam int IW = $clog2(N_REQ);

   state_t           state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    idx;
   logic [N_REQ-1:0] arb_gnt;
   logic [N_REQ-1:0] win_oh;
   logic [CNT_W-1:0] cnt;

   pes_rr_arb #(.N_REQ(N_REQ)) u_arb (
      .req   (req),
      .ptr   (ptr),
      .grant (arb_gnt),
      .idx   (idx)
   );

   assign busy = (state != IDLE);

   // alu_a/b/op double as the captured operand registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         cnt       <= '0;
         win_oh    <= '0;
         gnt       <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_op    <= '0;
      end else begin
         gnt       <= '0;
         rsp_valid <= '0;
         unique case (state)
            IDLE: begin
               if (|req) begin
                  gnt    <= arb_gnt;
                  win_oh <= arb_gnt;
                  alu_a  <= req_a[idx*DATA_W +: DATA_W];
                  alu_b  <= req_b[idx*DATA_W +: DATA_W];
                  alu_op <= req_op[idx*OP_W +: OP_W];
                  ptr    <= (idx == IW'(N_REQ-1)) ? '0 : idx + 1'b1;
                  state  <= ISSUE;
               end
            end
            ISSUE: begin
               cnt   <= CNT_W'(ALU_LAT-1);
               state <= WAIT;
            end
            WAIT: begin
               if (cnt == '0) begin
                  rsp_data  <= alu_r;
                  rsp_valid <= win_oh;
                  alu_a     <= '0;
                  alu_b     <= '0;
                  alu_op    <= '0;
                  state     <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pes_alu_sched.sv
// Scoreboard bench for pes_alu_sched with XOR ALU stubs (latency 1 and 3).
module tb_pes_alu_sched;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int OW = 3;

   typedef struct {
      int         idx;
      logic [7:0] data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req;
   logic [N*DW-1:0] req_a, req_b;
   logic [N*OW-1:0] req_op;

   logic [N-1:0]  gnt, rsp_valid, gnt3, rsp_valid3;
   logic [DW-1:0] rsp_data, alu_a, alu_b, alu_r;
   logic [DW-1:0] rsp_data3, alu_a3, alu_b3, alu_r3;
   logic [OW-1:0] alu_op, alu_op3;
   logic          busy, busy3;
   logic [DW-1:0] p3 [3];

   logic [7:0] ta [4] = '{8'h6A, 8'h12, 8'hC3, 8'h5A};
   logic [7:0] tb [4] = '{8'h3B, 8'h34, 8'h3C, 8'hA5};

   int   checks = 0;
   int   failures = 0;
   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   always_ff @(posedge clk) alu_r <= alu_a ^ alu_b;

   always_ff @(posedge clk) begin
      p3[0] <= alu_a3 ^ alu_b3;
      p3[1] <= p3[0];
      p3[2] <= p3[1];
   end
   assign alu_r3 = p3[2];

   pes_alu_sched #(.ALU_LAT(1)) dut (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
      .req_op(req_op), .gnt(gnt), .rsp_valid(rsp_valid),
      .rsp_data(rsp_data), .busy(busy), .alu_a(alu_a), .alu_b(alu_b),
      .alu_op(alu_op), .alu_r(alu_r)
   );

   pes_alu_sched #(.ALU_LAT(3)) dut3 (
      .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
      .req_op(req_op), .gnt(gnt3), .rsp_valid(rsp_valid3),
      .rsp_data(rsp_data3), .busy(busy3), .alu_a(alu_a3), .alu_b(alu_b3),
      .alu_op(alu_op3), .alu_r(alu_r3)
   );

   task automatic tick;
      @(negedge clk);
   endtask

   task automatic set_op(int i, logic [7:0] a, logic [7:0] b,
                         logic [2:0] op);
      req_a[i*DW +: DW]  = a;
      req_b[i*DW +: DW]  = b;
      req_op[i*OW +: OW] = op;
   endtask

   task automatic do_reset;
      tick;
      rst = 1'b1;
      req = '0;
      tick;
      rst = 1'b0;
   endtask

   task automatic pop_exp(output exp_t x);
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $display("FAIL sb_underflow actual=empty required=entry");
         x = '{-1, 8'h00};
      end else begin
         x = sb.pop_front();
      end
   endtask

   task automatic test_reset;
      tick;
      rst = 1'b1;
      #1;
      checks++;
      if ({gnt, rsp_valid, rsp_data, busy, alu_a, alu_b, alu_op} !== '0) begin
         failures++;
         $display("FAIL reset_outs actual=%b/%b/%h/%b/%h/%h/%h required=0",
                  gnt, rsp_valid, rsp_data, busy, alu_a, alu_b, alu_op);
      end
      checks++;
      if ({gnt3, rsp_valid3, rsp_data3, busy3, alu_a3, alu_b3, alu_op3}
          !== '0) begin
         failures++;
         $display("FAIL reset_outs3 actual=%b/%b/%h/%b required=0",
                  gnt3, rsp_valid3, rsp_data3, busy3);
      end
      tick;
      rst = 1'b0;
   endtask

   task automatic test_single;
      set_op(0, 8'h6A, 8'h3B, 3'b101);
      req = 4'b0001;
      sb.push_back('{0, 8'h51});
      tick;
      checks++;
      if (gnt !== 4'b0001) begin
         failures++;
         $display("FAIL single_gnt actual=%b required=0001", gnt);
      end
      checks++;
      if ({alu_a, alu_b, alu_op, busy} !== {8'h6A, 8'h3B, 3'b101, 1'b1}) begin
         failures++;
         $display("FAIL single_alu actual=%h/%h/%b/%b required=6a/3b/101/1",
                  alu_a, alu_b, alu_op, busy);
      end
      req = '0;
      set_op(0, 8'hFF, 8'h3B, 3'b000);
      tick;
      checks++;
      if ({gnt, rsp_valid} !== 8'h00) begin
         failures++;
         $display("FAIL single_wait actual=%b/%b required=0/0", gnt, rsp_valid);
      end
      tick;
      pop_exp(e);
      checks++;
      if (rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data) begin
         failures++;
         $display("FAIL single_rsp actual=%b/%h required=%b/%h",
                  rsp_valid, rsp_data, 4'b0001 << e.idx, e.data);
      end
      tick;
      checks++;
      if ({busy, rsp_valid, alu_a, alu_b, alu_op} !== '0) begin
         failures++;
         $display("FAIL single_idle actual=%b/%b/%h required=0/0/0",
                  busy, rsp_valid, alu_a);
      end
   endtask

   task automatic test_rr;
      logic [N-1:0] eg;
      do_reset;
      for (int i = 0; i < N; i++) set_op(i, ta[i], tb[i], 3'(i));
      for (int i = 0; i < 5; i++) sb.push_back('{i % N, ta[i%N] ^ tb[i%N]});
      req = 4'hF;
      for (int i = 0; i < 20; i++) begin
         tick;
         eg = (i % 4 == 0 && sb.size() > 0) ? (4'b0001 << sb[0].idx) : '0;
         checks++;
         if (gnt !== eg) begin
            failures++;
            $display("FAIL rr_gnt cyc=%0d actual=%b required=%b", i, gnt, eg);
         end
         if (i % 4 == 2) begin
            pop_exp(e);
            checks++;
            if (rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data) begin
               failures++;
               $display("FAIL rr_rsp cyc=%0d actual=%b/%h required=%b/%h",
                        i, rsp_valid, rsp_data, 4'b0001 << e.idx, e.data);
            end
         end else begin
            checks++;
            if (rsp_valid !== '0) begin
               failures++;
               $display("FAIL rr_rsp0 cyc=%0d actual=%b required=0000",
                        i, rsp_valid);
            end
         end
         checks++;
         if (busy !== (i % 4 != 3)) begin
            failures++;
            $display("FAIL rr_busy cyc=%0d actual=%b required=%b",
                     i, busy, i % 4 != 3);
         end
      end
      req = '0;
   endtask

   task automatic test_reset_mid;
      set_op(2, ta[2], tb[2], 3'b010);
      req = 4'b0100;
      tick;
      checks++;
      if (gnt !== 4'b0100) begin
         failures++;
         $display("FAIL mid_gnt actual=%b required=0100", gnt);
      end
      req = '0;
      tick;
      rst = 1'b1;
      #1;
      checks++;
      if ({gnt, rsp_valid, rsp_data, busy, alu_a, alu_b, alu_op} !== '0) begin
         failures++;
         $display("FAIL mid_reset actual=%b/%b/%h/%b/%h required=0",
                  gnt, rsp_valid, rsp_data, busy, alu_a);
      end
      tick;
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick;
         checks++;
         if ({rsp_valid, busy} !== '0) begin
            failures++;
            $display("FAIL mid_norsp cyc=%0d actual=%b/%b required=0/0",
                     i, rsp_valid, busy);
         end
      end
      req = 4'b0100;
      sb.push_back('{2, ta[2] ^ tb[2]});
      tick;
      checks++;
      if (gnt !== 4'b0100) begin
         failures++;
         $display("FAIL mid_regnt actual=%b required=0100", gnt);
      end
      req = '0;
      tick;
      tick;
      pop_exp(e);
      checks++;
      if (rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data) begin
         failures++;
         $display("FAIL mid_rsp actual=%b/%h required=%b/%h",
                  rsp_valid, rsp_data, 4'b0001 << e.idx, e.data);
      end
      tick;
      do_reset;
      set_op(1, ta[1], tb[1], 3'b001);
      set_op(3, ta[3], tb[3], 3'b011);
      req = 4'b1010;
      sb.push_back('{1, ta[1] ^ tb[1]});
      tick;
      checks++;
      if (gnt !== 4'b0010) begin
         failures++;
         $display("FAIL ptr_restart actual=%b required=0010", gnt);
      end
      req = '0;
      tick;
      tick;
      pop_exp(e);
      checks++;
      if (rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data) begin
         failures++;
         $display("FAIL ptr_rsp actual=%b/%h required=%b/%h",
                  rsp_valid, rsp_data, 4'b0001 << e.idx, e.data);
      end
      tick;
   endtask

   task automatic test_hold;
      logic [N-1:0] eg;
      do_reset;
      for (int i = 0; i < N; i++) set_op(i, ta[i], tb[i], 3'(i));
      req = 4'b0100;
      sb.push_back('{2, ta[2] ^ tb[2]});
      tick;
      checks++;
      if (gnt !== 4'b0100) begin
         failures++;
         $display("FAIL hold_gnt0 actual=%b required=0100", gnt);
      end
      req = 4'hF;
      sb.push_back('{3, ta[3] ^ tb[3]});
      sb.push_back('{0, ta[0] ^ tb[0]});
      sb.push_back('{1, ta[1] ^ tb[1]});
      sb.push_back('{2, ta[2] ^ tb[2]});
      for (int i = 1; i < 20; i++) begin
         tick;
         eg = (i % 4 == 0 && sb.size() > 0) ? (4'b0001 << sb[0].idx) : '0;
         checks++;
         if (gnt !== eg) begin
            failures++;
            $display("FAIL hold_gnt cyc=%0d actual=%b required=%b", i, gnt, eg);
         end
         if (i % 4 == 2) begin
            pop_exp(e);
            checks++;
            if (rsp_valid !== (4'b0001 << e.idx) || rsp_data !== e.data) begin
               failures++;
               $display("FAIL hold_rsp cyc=%0d actual=%b/%h required=%b/%h",
                        i, rsp_valid, rsp_data, 4'b0001 << e.idx, e.data);
            end
         end
      end
      req = '0;
   endtask

   task automatic test_lat3;
      do_reset;
      set_op(0, 8'h6A, 8'h3B, 3'b110);
      req = 4'b0001;
      sb.push_back('{0, 8'h51});
      tick;
      checks++;
      if (gnt3 !== 4'b0001) begin
         failures++;
         $display("FAIL lat3_gnt actual=%b required=0001", gnt3);
      end
      req = '0;
      set_op(0, 8'hFF, 8'h00, 3'b000);
      for (int i = 2; i <= 4; i++) begin
         tick;
         checks++;
         if ({alu_a3, alu_b3, alu_op3, rsp_valid3}
             !== {8'h6A, 8'h3B, 3'b110, 4'b0000}) begin
            failures++;
            $display("FAIL lat3_hold cyc=%0d actual=%h/%h/%b/%b required=6a/3b/110/0000",
                     i, alu_a3, alu_b3, alu_op3, rsp_valid3);
         end
      end
      tick;
      pop_exp(e);
      checks++;
      if (rsp_valid3 !== (4'b0001 << e.idx) || rsp_data3 !== e.data) begin
         failures++;
         $display("FAIL lat3_rsp actual=%b/%h required=%b/%h",
                  rsp_valid3, rsp_data3, 4'b0001 << e.idx, e.data);
      end
      tick;
      checks++;
      if ({busy3, rsp_valid3} !== '0) begin
         failures++;
         $display("FAIL lat3_idle actual=%b/%b required=0/0", busy3, rsp_valid3);
      end
   endtask

   initial begin
      rst    = 1'b1;
      req    = '0;
      req_a  = '0;
      req_b  = '0;
      req_op = '0;
      test_reset;
      test_single;
      test_rr;
      test_reset_mid;
      test_hold;
      test_lat3;
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL sb_leftover actual=%0d required=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pes_alu_sched.md
PES_ALU_SCHED -- requirements
Module: pes_alu_sched

Interface
REQ-001 Parameter N_REQ, 4, number of requesters sharing the ALU.
REQ-002 Parameter DATA_W, 8, ALU operand/result width.
REQ-003 Parameter OP_W, 3, ALU opcode width.
REQ-004 Parameter ALU_LAT, 1, ALU clock cycles from operands sampled to R valid (1..4).
REQ-005 One clock; reset is asynchronous and active-high.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-high reset.
REQ-008 req  in  N_REQ  per-requester request level.
REQ-009 req_a  in  N_REQ*DATA_W  flattened A operands; slice i belongs to requester i.
REQ-010 req_b  in  N_REQ*DATA_W  flattened B operands.
REQ-011 req_op  in  N_REQ*OP_W  flattened opcodes.
REQ-012 gnt  out  N_REQ  one-hot grant pulse; operands were captured.
REQ-013 rsp_valid  out  N_REQ  one-hot result-valid pulse.
REQ-014 rsp_data  out  DATA_W  result, meaningful only while a rsp_valid bit is high.
REQ-015 busy  out  1  high in any state other than IDLE.
REQ-016 alu_a, alu_b  out  DATA_W each  operands driven to the shared ALU.
REQ-017 alu_op  out  OP_W  opcode driven to the shared ALU.
REQ-018 alu_r  in  DATA_W  registered ALU result.

Function
REQ-019 FSM states: IDLE, ISSUE, WAIT, RESP.
REQ-020 IDLE: when any req bit is high, the block SHALL pick the winner round-robin, capture its a/b/op, register gnt[winner]=1 and go to ISSUE.
REQ-021 ISSUE (1 cycle): gnt high, alu_a/alu_b/alu_op driven from the captured registers; the next state is WAIT.
REQ-022 WAIT: ALU_LAT cycles counted by a down-counter; alu ports hold their values; on the last cycle alu_r is captured into rsp_data; the next state is RESP.
REQ-023 RESP (1 cycle): rsp_valid[winner]=1; the next state is IDLE.
REQ-024 Latency: with req first seen at edge k, gnt is high in cycle k+1 and rsp_valid in cycle k+2+ALU_LAT; throughput is one operation per 3+ALU_LAT cycles.
REQ-025 Round-robin: the pointer resets to 0; search starts at the pointer upward with wrap; after granting i, pointer=(i+1) mod N_REQ.
REQ-026 Req bits sampled outside IDLE SHALL be ignored; a requester still holding req when the block returns to IDLE is a new request.
REQ-027 Operand changes after the capture edge SHALL NOT affect the in-flight result.
REQ-028 gnt and rsp_valid SHALL each be at most one-hot and are never high together.
REQ-029 alu_a/alu_b/alu_op SHALL be 0 in IDLE.
REQ-030 No arithmetic in this block; rsp_data = alu_r bit-exact.

Reset
REQ-031 rst forces IDLE, pointer=0, counter=0, and gnt, rsp_valid, rsp_data, busy, alu_a, alu_b, alu_op all to 0, immediately and asynchronously.
REQ-032 Reset mid-operation SHALL abandon the in-flight request; no rsp_valid is issued for it after release.
REQ-033 The first arbitration after reset release starts at requester 0.

Structure
REQ-034 Package pes_alu_pkg SHALL hold the DATA_W/OP_W/N_REQ defaults and the FSM state enum.
REQ-035 Round-robin pick SHALL be a sub-module pes_rr_arb (inputs req, pointer; outputs one-hot grant, index).
REQ-036 The ALU is external; the bench uses a stub with registered R = A ^ B after ALU_LAT cycles.

Verification
REQ-037 Single request: req=0001, a0=0x6A, b0=0x3B, op0=0 -> gnt=0001 at k+1, rsp_valid=0001 with rsp_data=0x51 at k+3.
REQ-038 All four requests held high -> grants in the order 0,1,2,3,0, each gnt 4 cycles apart, with busy continuously high except the IDLE cycles.
REQ-039 Operand change: after gnt, change a0 to 0xFF -> rsp_data is still 0x51.
REQ-040 Reset asserted during WAIT -> all outputs 0 at once, no rsp_valid; then req=0100 -> gnt=0100 (pointer restarted at 0).
REQ-041 ALU_LAT=3 build: single request -> rsp_valid at k+5; alu ports stable through WAIT.
REQ-042 Requester 2 holds req through RESP -> it is regranted only after requesters 3,0,1 (if requesting) per the pointer.
